// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: FSM states, frame length, and
// the microsecond-to-clock-cycle conversion helper.
package ps2_pkg;

  localparam int PS2_FRAME_BITS = 11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INHIBIT,
    ST_START,
    ST_BITS,
    ST_ACK,
    ST_WAIT_IDLE,
    ST_FIN
  } ps2_state_e;

  function automatic int us_to_cycles(
    input int clk_hz,
    input int us
  );
    return (clk_hz / 1_000_000) * us;
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// 2-FF synchronizer for the PS/2 clock and data pads plus a
// falling-edge detector on the synchronized clock.
// Ports: clk/reset, raw pads in, synced lines and clk_fall_o out.
module ps2_line_sync (
  input  logic clk,
  input  logic reset,
  input  logic ps2_clk_i,
  input  logic ps2_data_i,
  output logic clk_s_o,
  output logic data_s_o,
  output logic clk_fall_o
);

  logic clk_meta_q;
  logic clk_sync_q;
  logic clk_prev_q;
  logic data_meta_q;
  logic data_sync_q;

  // Reset to the idle-high bus level so no edge is seen at startup.
  always_ff @(posedge clk) begin
    if (reset) begin
      clk_meta_q  <= 1'b1;
      clk_sync_q  <= 1'b1;
      clk_prev_q  <= 1'b1;
      data_meta_q <= 1'b1;
      data_sync_q <= 1'b1;
    end else begin
      clk_meta_q  <= ps2_clk_i;
      clk_sync_q  <= clk_meta_q;
      clk_prev_q  <= clk_sync_q;
      data_meta_q <= ps2_data_i;
      data_sync_q <= data_meta_q;
    end
  end

  assign clk_s_o    = clk_sync_q;
  assign data_s_o   = data_sync_q;
  assign clk_fall_o = clk_prev_q & ~clk_sync_q;

endmodule

// File: rtl/ps2_transmitter.sv
// Host-to-device PS/2 transmitter: inhibit, request-to-send,
// 8 data bits + odd parity + stop on device clock, ACK check.
// Ports: clk/reset, data/valid/ready byte handshake,
// ps2_*_in raw pads, ps2_*_oe pull-low enables,
// tx_active busy flag, done/error one-cycle result pulses.
module ps2_transmitter
  import ps2_pkg::*;
#(
  parameter int CLK_HZ     = 48_000_000,
  parameter int INHIBIT_US = 100,
  parameter int TIMEOUT_US = 15000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] data,
  input  logic       valid,
  output logic       ready,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       tx_active,
  output logic       done,
  output logic       error
);

  localparam int INH_CYC   = us_to_cycles(CLK_HZ, INHIBIT_US);
  localparam int START_CYC = us_to_cycles(CLK_HZ, 1);
  localparam int TO_CYC    = us_to_cycles(CLK_HZ, TIMEOUT_US);
  localparam int PH_MAX    =
    (INH_CYC > START_CYC) ? INH_CYC : START_CYC;
  localparam int PH_W      = $clog2(PH_MAX);
  localparam int TO_W      = $clog2(TO_CYC);

  logic clk_s;
  logic data_s;
  logic clk_fall;

  ps2_line_sync u_sync (
    .clk        (clk),
    .reset      (reset),
    .ps2_clk_i  (ps2_clk_in),
    .ps2_data_i (ps2_data_in),
    .clk_s_o    (clk_s),
    .data_s_o   (data_s),
    .clk_fall_o (clk_fall)
  );

  ps2_state_e      state_q, state_d;
  logic [PH_W-1:0] ph_q, ph_d;
  logic [TO_W-1:0] to_q, to_d;
  logic [3:0]      idx_q, idx_d;
  logic [8:0]      tx_q, tx_d;
  logic            clk_oe_q, clk_oe_d;
  logic            data_oe_q, data_oe_d;
  logic            nack_q, nack_d;
  logic            done_q, done_d;
  logic            err_q, err_d;
  logic            timed_out;

  assign timed_out = (to_q == TO_W'(TO_CYC - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      ph_q      <= '0;
      to_q      <= '0;
      idx_q     <= '0;
      tx_q      <= '0;
      clk_oe_q  <= 1'b0;
      data_oe_q <= 1'b0;
      nack_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      ph_q      <= ph_d;
      to_q      <= to_d;
      idx_q     <= idx_d;
      tx_q      <= tx_d;
      clk_oe_q  <= clk_oe_d;
      data_oe_q <= data_oe_d;
      nack_q    <= nack_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    ph_d      = ph_q;
    to_d      = to_q;
    idx_d     = idx_q;
    tx_d      = tx_q;
    clk_oe_d  = clk_oe_q;
    data_oe_d = data_oe_q;
    nack_d    = nack_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (valid) begin
          tx_d     = {~^data, data};
          ph_d     = '0;
          clk_oe_d = 1'b1;
          state_d  = ST_INHIBIT;
        end
      end
      ST_INHIBIT: begin
        if (ph_q == PH_W'(INH_CYC - 1)) begin
          ph_d      = '0;
          data_oe_d = 1'b1;
          state_d   = ST_START;
        end else begin
          ph_d = ph_q + 1'b1;
        end
      end
      ST_START: begin
        if (ph_q == PH_W'(START_CYC - 1)) begin
          clk_oe_d = 1'b0;
          idx_d    = '0;
          to_d     = '0;
          state_d  = ST_BITS;
        end else begin
          ph_d = ph_q + 1'b1;
        end
      end
      ST_BITS: begin
        to_d = to_q + 1'b1;
        if (timed_out) begin
          state_d = ST_FIN;
        end else if (clk_fall) begin
          // idx counts edges already seen; edge 10 is the stop bit
          if (idx_q == 4'(PS2_FRAME_BITS - 2)) begin
            data_oe_d = 1'b0;
            state_d   = ST_ACK;
          end else begin
            data_oe_d = ~tx_q[idx_q];
            idx_d     = idx_q + 1'b1;
          end
        end
      end
      ST_ACK: begin
        to_d = to_q + 1'b1;
        if (timed_out) begin
          state_d = ST_FIN;
        end else if (clk_fall) begin
          nack_d  = data_s;
          state_d = ST_WAIT_IDLE;
        end
      end
      ST_WAIT_IDLE: begin
        to_d = to_q + 1'b1;
        if (timed_out) begin
          state_d = ST_FIN;
        end else if (clk_s && data_s) begin
          done_d  = 1'b1;
          err_d   = nack_q;
          state_d = ST_FIN;
        end
      end
      ST_FIN: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    // Timeout abort: release both lines and report an error.
    if (timed_out && (state_q == ST_BITS ||
                      state_q == ST_ACK ||
                      state_q == ST_WAIT_IDLE)) begin
      clk_oe_d  = 1'b0;
      data_oe_d = 1'b0;
      done_d    = 1'b1;
      err_d     = 1'b1;
    end
  end

  assign ready       = (state_q == ST_IDLE);
  assign tx_active   = (state_q != ST_IDLE);
  assign ps2_clk_oe  = clk_oe_q;
  assign ps2_data_oe = data_oe_q;
  assign done        = done_q;
  assign error       = err_q;

endmodule

// File: tb/tb_ps2_transmitter.sv
// Bench for ps2_transmitter with an open-drain bus and a
// behavioural PS/2 device model that clocks frames and ACKs.
module tb_ps2_transmitter;

  localparam int CLK_HZ = 4_000_000;
  localparam int INH    = 400;
  localparam int STC    = 4;
  localparam int TO     = 8000;
  localparam int HALF   = 20;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] data;
  logic       valid;
  logic       ready;
  logic       ps2_clk_in;
  logic       ps2_data_in;
  logic       clk_oe;
  logic       data_oe;
  logic       tx_active;
  logic       done;
  logic       err;

  logic dev_clk_low;
  logic dev_data_low;
  logic alt_en;

  int nvec  = 0;
  int nfail = 0;

  always #5 clk = ~clk;

  assign ps2_clk_in  = ~(clk_oe | dev_clk_low);
  assign ps2_data_in = ~(data_oe | dev_data_low);

  ps2_transmitter #(
    .CLK_HZ     (CLK_HZ),
    .INHIBIT_US (100),
    .TIMEOUT_US (2000)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .data        (data),
    .valid       (valid),
    .ready       (ready),
    .ps2_clk_in  (ps2_clk_in),
    .ps2_data_in (ps2_data_in),
    .ps2_clk_oe  (clk_oe),
    .ps2_data_oe (data_oe),
    .tx_active   (tx_active),
    .done        (done),
    .error       (err)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  // Wire-level frame after the start bit: data LSB first,
  // odd parity, stop.
  function automatic logic [9:0] ref_frame(input logic [7:0] b);
    logic [9:0] f;
    f[7:0] = b;
    f[8]   = ($countones(b) % 2 == 0);
    f[9]   = 1'b1;
    return f;
  endfunction

  task automatic tick();
    @(negedge clk);
    if (alt_en) data = ~data;
  endtask

  task automatic accept(input logic [7:0] b);
    data  = b;
    valid = 1'b1;
    tick();
    chk("accept_clk_oe", 32'(clk_oe), 1);
    chk("accept_active", 32'(tx_active), 1);
    chk("accept_ready", 32'(ready), 0);
    if (!alt_en) valid = 1'b0;
  endtask

  task automatic inhibit_phase();
    int n_clk = 0;
    int n_nod = 0;
    for (int g = 0; g < 20000 && clk_oe; g++) begin
      n_clk++;
      if (!data_oe) n_nod++;
      tick();
    end
    chk("clk_oe_cycles", 32'(n_clk), INH + STC);
    chk("data_oe_rise", 32'(n_nod), INH);
    chk("start_bit", 32'(data_oe), 1);
  endtask

  task automatic device_pulse();
    dev_clk_low = 1'b1;
    repeat (HALF) tick();
    dev_clk_low = 1'b0;
    repeat (HALF) tick();
  endtask

  task automatic device_frame(input bit ack,
                              output logic [9:0] bits);
    repeat (8) tick();
    for (int k = 0; k < 10; k++) begin
      dev_clk_low = 1'b1;
      repeat (HALF) tick();
      dev_clk_low = 1'b0;
      repeat (HALF / 2) tick();
      bits[k] = ps2_data_in;
      repeat (HALF / 2) tick();
    end
    dev_data_low = ack;
    repeat (HALF / 2) tick();
    dev_clk_low = 1'b1;
    repeat (HALF) tick();
    dev_clk_low = 1'b0;
  endtask

  task automatic wait_done(input bit exp_err);
    bit got = 1'b0;
    for (int i = 0; i < 300 && !got; i++) begin
      if (i == 4) dev_data_low = 1'b0;
      tick();
      if (done) got = 1'b1;
    end
    dev_data_low = 1'b0;
    chk("done_seen", 32'(got), 1);
    chk("done_error", 32'(err), 32'(exp_err));
    chk("oe_at_done", 32'({clk_oe, data_oe}), 0);
  endtask

  task automatic send(input logic [7:0] b, input bit ack,
                      output logic [9:0] bits);
    accept(b);
    inhibit_phase();
    device_frame(ack, bits);
    wait_done(!ack);
    tick();
    chk("ready_after_done", 32'(ready), 1);
    chk("done_one_cycle", 32'(done), 0);
    chk("frame_bits", 32'(bits), 32'(ref_frame(b)));
  endtask

  initial begin
    logic [9:0] bits;
    logic [7:0] a;
    logic [7:0] b2;
    int n;
    bit got;

    reset        = 1'b1;
    valid        = 1'b0;
    data         = 8'h00;
    dev_clk_low  = 1'b0;
    dev_data_low = 1'b0;
    alt_en       = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    chk("rst_ready", 32'(ready), 1);
    chk("rst_active", 32'(tx_active), 0);
    chk("rst_oe", 32'({clk_oe, data_oe}), 0);
    chk("rst_done_err", 32'({done, err}), 0);

    send(8'hED, 1'b1, bits);
    send(8'h01, 1'b1, bits);
    chk("parity_01", 32'(bits[8]), 0);
    send(8'hFF, 1'b1, bits);
    chk("parity_ff", 32'(bits[8]), 1);
    send(8'h5A, 1'b0, bits);

    // Device never clocks: timeout from the first BITS cycle.
    accept(8'h3C);
    inhibit_phase();
    n   = 0;
    got = 1'b0;
    for (int i = 0; i < TO + 100 && !got; i++) begin
      tick();
      n++;
      if (done) got = 1'b1;
    end
    chk("to_seen", 32'(got), 1);
    chk("to_cycles", 32'(n), TO);
    chk("to_error", 32'(err), 1);
    chk("to_oe", 32'({clk_oe, data_oe}), 0);
    tick();
    chk("to_ready", 32'(ready), 1);

    // Reset after four device clock edges.
    accept(8'hA7);
    inhibit_phase();
    repeat (8) tick();
    repeat (4) device_pulse();
    reset = 1'b1;
    tick();
    chk("mid_rst_oe", 32'({clk_oe, data_oe}), 0);
    chk("mid_rst_active", 32'(tx_active), 0);
    chk("mid_rst_ready", 32'(ready), 1);
    chk("mid_rst_done", 32'(done), 0);
    reset = 1'b0;
    tick();
    send(8'hF4, 1'b1, bits);

    // valid held high with data toggling every cycle.
    a      = 8'(($urandom));
    alt_en = 1'b1;
    accept(a);
    inhibit_phase();
    device_frame(1'b1, bits);
    wait_done(1'b0);
    chk("held_first", 32'(bits), 32'(ref_frame(a)));
    tick();
    chk("held_ready", 32'(ready), 1);
    b2 = data;
    tick();
    chk("held_accept", 32'({tx_active, ready}), 32'h2);
    alt_en = 1'b0;
    valid  = 1'b0;
    inhibit_phase();
    device_frame(1'b1, bits);
    wait_done(1'b0);
    chk("held_second", 32'(bits), 32'(ref_frame(b2)));
    tick();

    for (int r = 0; r < 6; r++) begin
      a = 8'($urandom);
      send(a, ($urandom_range(0, 3) != 0), bits);
      repeat ($urandom_range(0, 5)) tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nfail);
    $finish;
  end

endmodule
